// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register: captures the MEM-stage slot, then forms the
// register-file write (load extension, link address, misalignment, $zero).
module mem_wb_stage #(
    parameter int RETIRE_WIDTH = 32
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    stall,
    input  logic                    flush,
    input  logic                    in_valid,
    input  logic [31:0]             in_pc,
    input  logic [31:0]             in_aluResult,
    input  logic [31:0]             in_memData,
    input  logic                    in_regWrite,
    input  logic                    in_memToReg,
    input  logic                    in_link,
    input  logic [2:0]              in_loadType,
    input  logic [4:0]              in_writeAddress,
    output logic                    shouldWrite,
    output logic [4:0]              writeAddress,
    output logic [31:0]             writeData,
    output logic                    wb_valid,
    output logic                    misaligned,
    output logic [RETIRE_WIDTH-1:0] retired
);

    typedef enum logic [2:0] {
        LT_LW  = 3'd0,
        LT_LB  = 3'd1,
        LT_LBU = 3'd2,
        LT_LH  = 3'd3,
        LT_LHU = 3'd4
    } load_type_e;

    logic                    valid_q,      valid_d;
    logic [31:0]             pc_q,         pc_d;
    logic [31:0]             alu_q,        alu_d;
    logic [31:0]             mem_q,        mem_d;
    logic                    reg_write_q,  reg_write_d;
    logic                    mem_to_reg_q, mem_to_reg_d;
    logic                    link_q,       link_d;
    logic [2:0]              load_type_q,  load_type_d;
    logic [4:0]              waddr_q,      waddr_d;
    logic [RETIRE_WIDTH-1:0] retired_q,    retired_d;

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        valid_d      = valid_q;
        pc_d         = pc_q;
        alu_d        = alu_q;
        mem_d        = mem_q;
        reg_write_d  = reg_write_q;
        mem_to_reg_d = mem_to_reg_q;
        link_d       = link_q;
        load_type_d  = load_type_q;
        waddr_d      = waddr_q;
        retired_d    = retired_q;

        if (flush) begin
            // Bubble: only the control bits matter; data fields keep stale values.
            valid_d     = 1'b0;
            reg_write_d = 1'b0;
            link_d      = 1'b0;
        end else if (!stall) begin
            valid_d      = in_valid;
            pc_d         = in_pc;
            alu_d        = in_aluResult;
            mem_d        = in_memData;
            reg_write_d  = in_regWrite;
            mem_to_reg_d = in_memToReg;
            link_d       = in_link;
            load_type_d  = in_loadType;
            waddr_d      = in_writeAddress;
            if (in_valid)
                retired_d = retired_q + RETIRE_WIDTH'(1);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            valid_q      <= 1'b0;
            pc_q         <= '0;
            alu_q        <= '0;
            mem_q        <= '0;
            reg_write_q  <= 1'b0;
            mem_to_reg_q <= 1'b0;
            link_q       <= 1'b0;
            load_type_q  <= '0;
            waddr_q      <= '0;
            retired_q    <= '0;
        end else begin
            valid_q      <= valid_d;
            pc_q         <= pc_d;
            alu_q        <= alu_d;
            mem_q        <= mem_d;
            reg_write_q  <= reg_write_d;
            mem_to_reg_q <= mem_to_reg_d;
            link_q       <= link_d;
            load_type_q  <= load_type_d;
            waddr_q      <= waddr_d;
            retired_q    <= retired_d;
        end
    end

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;
    logic [31:0] load_data;
    logic        load_misaligned;

    always_comb begin
        byte_lane = 8'h00;
        case (alu_q[1:0])
            2'd0:    byte_lane = mem_q[7:0];
            2'd1:    byte_lane = mem_q[15:8];
            2'd2:    byte_lane = mem_q[23:16];
            default: byte_lane = mem_q[31:24];
        endcase
        half_lane = alu_q[1] ? mem_q[31:16] : mem_q[15:0];

        load_data       = mem_q;
        load_misaligned = (alu_q[1:0] != 2'd0);
        case (load_type_q)
            LT_LB: begin
                load_data       = {{24{byte_lane[7]}}, byte_lane};
                load_misaligned = 1'b0;
            end
            LT_LBU: begin
                load_data       = {24'h0, byte_lane};
                load_misaligned = 1'b0;
            end
            LT_LH: begin
                load_data       = {{16{half_lane[15]}}, half_lane};
                load_misaligned = alu_q[0];
            end
            LT_LHU: begin
                load_data       = {16'h0, half_lane};
                load_misaligned = alu_q[0];
            end
            default: ;  // LW and the unused encodings
        endcase
    end

    always_comb begin
        misaligned   = mem_to_reg_q & load_misaligned;
        wb_valid     = valid_q;
        writeAddress = waddr_q;
        retired      = retired_q;
        if (link_q)
            writeData = pc_q + 32'd8;
        else if (mem_to_reg_q)
            writeData = load_data;
        else
            writeData = alu_q;
        shouldWrite = valid_q & reg_write_q & (waddr_q != 5'd0) & ~misaligned;
    end

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed bench for mem_wb_stage; a second narrow-counter instance covers
// retired wrap-around within a few cycles.
module tb_mem_wb_stage;

    logic        clock;
    logic        reset;
    logic        stall;
    logic        flush;
    logic        in_valid;
    logic [31:0] in_pc;
    logic [31:0] in_aluResult;
    logic [31:0] in_memData;
    logic        in_regWrite;
    logic        in_memToReg;
    logic        in_link;
    logic [2:0]  in_loadType;
    logic [4:0]  in_writeAddress;

    logic        shouldWrite;
    logic [4:0]  writeAddress;
    logic [31:0] writeData;
    logic        wb_valid;
    logic        misaligned;
    logic [31:0] retired;

    logic        w_shouldWrite;
    logic [4:0]  w_writeAddress;
    logic [31:0] w_writeData;
    logic        w_wb_valid;
    logic        w_misaligned;
    logic [2:0]  w_retired;

    int n_total;
    int n_bad;

    mem_wb_stage dut (
        .clock(clock), .reset(reset), .stall(stall), .flush(flush),
        .in_valid(in_valid), .in_pc(in_pc), .in_aluResult(in_aluResult),
        .in_memData(in_memData), .in_regWrite(in_regWrite),
        .in_memToReg(in_memToReg), .in_link(in_link),
        .in_loadType(in_loadType), .in_writeAddress(in_writeAddress),
        .shouldWrite(shouldWrite), .writeAddress(writeAddress),
        .writeData(writeData), .wb_valid(wb_valid),
        .misaligned(misaligned), .retired(retired)
    );

    mem_wb_stage #(.RETIRE_WIDTH(3)) dut_w (
        .clock(clock), .reset(reset), .stall(stall), .flush(flush),
        .in_valid(in_valid), .in_pc(in_pc), .in_aluResult(in_aluResult),
        .in_memData(in_memData), .in_regWrite(in_regWrite),
        .in_memToReg(in_memToReg), .in_link(in_link),
        .in_loadType(in_loadType), .in_writeAddress(in_writeAddress),
        .shouldWrite(w_shouldWrite), .writeAddress(w_writeAddress),
        .writeData(w_writeData), .wb_valid(w_wb_valid),
        .misaligned(w_misaligned), .retired(w_retired)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] alu,
                         input logic [31:0] mem, input logic rw, input logic m2r,
                         input logic lnk, input logic [2:0] lt, input logic [4:0] wa);
        in_valid        = v;
        in_pc           = pc;
        in_aluResult    = alu;
        in_memData      = mem;
        in_regWrite     = rw;
        in_memToReg     = m2r;
        in_link         = lnk;
        in_loadType     = lt;
        in_writeAddress = wa;
    endtask

    // Advance one rising edge and settle just after it.
    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".sw"},  {31'h0, shouldWrite}, 32'h0);
        check({tag, ".wa"},  {27'h0, writeAddress}, 32'h0);
        check({tag, ".wd"},  writeData, 32'h0);
        check({tag, ".vld"}, {31'h0, wb_valid}, 32'h0);
        check({tag, ".mis"}, {31'h0, misaligned}, 32'h0);
        check({tag, ".ret"}, retired, 32'h0);
    endtask

    localparam logic [31:0] MEMW = 32'h8081_F2F3;

    initial begin
        n_total = 0;
        n_bad   = 0;
        reset   = 1'b1;
        stall   = 1'b0;
        flush   = 1'b0;
        drive(1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 3'd0, 5'd0);
        #3;
        check_all_zero("rst");
        @(negedge clock);
        reset = 1'b0;

        // ALU write-back
        drive(1'b1, 32'h100, 32'h0000_1234, 32'h0, 1'b1, 1'b0, 1'b0, 3'd0, 5'd5);
        cyc();
        check("alu.sw",  {31'h0, shouldWrite}, 32'h1);
        check("alu.wa",  {27'h0, writeAddress}, 32'd5);
        check("alu.wd",  writeData, 32'h0000_1234);
        check("alu.vld", {31'h0, wb_valid}, 32'h1);
        check("alu.ret", retired, 32'd1);

        // Load extension
        drive(1'b1, 32'h104, 32'h0000_2001, MEMW, 1'b1, 1'b1, 1'b0, 3'd1, 5'd6);
        cyc();
        check("lb.wd",  writeData, 32'hFFFF_FFF2);
        check("lb.sw",  {31'h0, shouldWrite}, 32'h1);
        check("lb.mis", {31'h0, misaligned}, 32'h0);
        in_loadType = 3'd2;
        cyc();
        check("lbu.wd", writeData, 32'h0000_00F2);
        in_loadType  = 3'd3;
        in_aluResult = 32'h0000_2002;
        cyc();
        check("lh.wd",  writeData, 32'hFFFF_8081);
        in_loadType = 3'd4;
        cyc();
        check("lhu.wd", writeData, 32'h0000_8081);
        in_loadType  = 3'd0;
        in_aluResult = 32'h0000_2000;
        cyc();
        check("lw.wd",  writeData, MEMW);
        check("lw.mis", {31'h0, misaligned}, 32'h0);
        in_loadType  = 3'd7;
        in_aluResult = 32'h0000_2002;
        cyc();
        check("lt7.mis", {31'h0, misaligned}, 32'h1);
        check("lt7.sw",  {31'h0, shouldWrite}, 32'h0);
        check("lt7.ret", retired, 32'd7);

        // Misaligned halfword and $zero destination
        drive(1'b1, 32'h120, 32'h0000_1001, MEMW, 1'b1, 1'b1, 1'b0, 3'd3, 5'd6);
        cyc();
        check("lhmis.mis", {31'h0, misaligned}, 32'h1);
        check("lhmis.sw",  {31'h0, shouldWrite}, 32'h0);
        drive(1'b1, 32'h124, 32'h0000_00AA, 32'h0, 1'b1, 1'b0, 1'b0, 3'd0, 5'd0);
        cyc();
        check("zero.sw",  {31'h0, shouldWrite}, 32'h0);
        check("zero.vld", {31'h0, wb_valid}, 32'h1);

        // Link beats memToReg
        drive(1'b1, 32'h0040_0010, 32'h0000_2000, MEMW, 1'b1, 1'b1, 1'b1, 3'd0, 5'd31);
        cyc();
        check("link.wd",  writeData, 32'h0040_0018);
        check("link.sw",  {31'h0, shouldWrite}, 32'h1);
        check("link.ret", retired, 32'd10);

        // Stall holds everything for three cycles
        stall = 1'b1;
        drive(1'b1, 32'h200, 32'h0000_DEAD, 32'h0, 1'b1, 1'b0, 1'b0, 3'd0, 5'd7);
        for (int i = 0; i < 3; i++) begin
            cyc();
            check($sformatf("stall%0d.wd", i), writeData, 32'h0040_0018);
            check($sformatf("stall%0d.wa", i), {27'h0, writeAddress}, 32'd31);
            check($sformatf("stall%0d.ret", i), retired, 32'd10);
        end

        // Flush wins over stall
        flush = 1'b1;
        cyc();
        check("flush.vld", {31'h0, wb_valid}, 32'h0);
        check("flush.sw",  {31'h0, shouldWrite}, 32'h0);
        check("flush.ret", retired, 32'd10);
        stall = 1'b0;
        flush = 1'b0;

        drive(1'b1, 32'h204, 32'h0000_0055, 32'h0, 1'b1, 1'b0, 1'b0, 3'd0, 5'd3);
        cyc();
        check("resume.wd",  writeData, 32'h0000_0055);
        check("resume.ret", retired, 32'd11);
        in_valid = 1'b0;
        cyc();
        check("bubble.vld", {31'h0, wb_valid}, 32'h0);
        check("bubble.ret", retired, 32'd11);

        // Reset arriving mid-cycle during a stall clears outputs at once
        drive(1'b1, 32'h208, 32'h0000_0066, 32'h0, 1'b1, 1'b0, 1'b0, 3'd0, 5'd9);
        cyc();
        check("pre.sw", {31'h0, shouldWrite}, 32'h1);
        stall = 1'b1;
        #2;
        reset = 1'b1;
        #1;
        check_all_zero("arst");
        #1;
        reset = 1'b0;
        stall = 1'b0;
        drive(1'b1, 32'h300, 32'h0000_0077, 32'h0, 1'b1, 1'b0, 1'b0, 3'd0, 5'd4);
        cyc();
        check("post.wd",  writeData, 32'h0000_0077);
        check("post.sw",  {31'h0, shouldWrite}, 32'h1);
        check("post.ret", retired, 32'd1);
        check("w.ret1",   {29'h0, w_retired}, 32'd1);

        // Narrow counter: 6 more to reach its maximum, one more wraps it
        for (int i = 0; i < 6; i++) cyc();
        check("w.max",  {29'h0, w_retired}, 32'd7);
        cyc();
        check("w.wrap", {29'h0, w_retired}, 32'd0);
        check("ret8",   retired, 32'd8);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/mem_wb_stage.md
MEM_WB_STAGE -- requirements
Module: mem_wb_stage

Interface
REQ-001 SHALL have parameter RETIRE_WIDTH, default 32, giving the width of the retired-instruction counter.
REQ-002 SHALL have port clock, input, 1, rising-edge clock for the stage register.
REQ-003 SHALL have port reset, input, 1, reset, asynchronous, active-high.
REQ-004 SHALL have port stall, input, 1, hold the stage register contents.
REQ-005 SHALL have port flush, input, 1, load a bubble into the stage register.
REQ-006 SHALL have port in_valid, input, 1, MEM-stage slot holds a real instruction.
REQ-007 SHALL have port in_pc, input, 32, instruction PC.
REQ-008 SHALL have port in_aluResult, input, 32, ALU result and memory address.
REQ-009 SHALL have port in_memData, input, 32, raw aligned word read from data memory.
REQ-010 SHALL have port in_regWrite, input, 1, instruction writes a register.
REQ-011 SHALL have port in_memToReg, input, 1, write-back source is the load data.
REQ-012 SHALL have port in_link, input, 1, write-back source is in_pc+8 (JAL/JALR).
REQ-013 SHALL have port in_loadType, input, 3, load type: 0 LW, 1 LB, 2 LBU, 3 LH, 4 LHU; 5-7 treated as LW.
REQ-014 SHALL have port in_writeAddress, input, 5, destination register.
REQ-015 SHALL have port shouldWrite, output, 1, register-file write enable.
REQ-016 SHALL have port writeAddress, output, 5, register-file write address.
REQ-017 SHALL have port writeData, output, 32, register-file write data.
REQ-018 SHALL have port wb_valid, output, 1, stage register holds a real instruction.
REQ-019 SHALL have port misaligned, output, 1, the held load is misaligned.
REQ-020 SHALL have port retired, output, RETIRE_WIDTH, count of instructions accepted into the stage.

Function
REQ-021 SHALL register all in_* inputs on the rising clock edge; all outputs derive combinationally from the registered state only, giving one cycle of latency.
REQ-022 SHALL apply capture priority reset > flush > stall > normal capture.
REQ-023 SHALL on flush clear the registered valid, regWrite and link bits, leaving the data fields don't-care.
REQ-024 SHALL on stall without flush hold every registered field and the retired count unchanged.
REQ-025 SHALL increment retired by 1 on each edge where in_valid=1, flush=0 and stall=0, wrapping from 2^RETIRE_WIDTH-1 to 0.
REQ-026 SHALL use little-endian byte lanes: LB/LBU select byte aluResult[1:0]; LH/LHU select halfword aluResult[1].
REQ-027 SHALL sign-extend the selected lane for LB and LH, and zero-extend it for LBU and LHU.
REQ-028 SHALL assert misaligned when memToReg=1 and either LH/LHU has aluResult[0]=1 or LW has aluResult[1:0]!=0.
REQ-029 SHALL select writeData as pc+8 if link=1, else the extended load data if memToReg=1, else aluResult; link takes precedence over memToReg.
REQ-030 SHALL assert shouldWrite = wb_valid & regWrite & (writeAddress!=0) & !misaligned.
REQ-031 SHALL hold outputs stable for the whole cycle so that a negedge-writing register file samples settled values.

Reset
REQ-032 SHALL on reset asynchronously clear valid, regWrite, link, memToReg and retired, and set all data and address fields to 0.
REQ-033 SHALL, while reset is asserted, drive shouldWrite=0, writeAddress=0, writeData=0, wb_valid=0, misaligned=0 and retired=0.
REQ-034 SHALL, when reset asserts mid-stall, discard the held instruction, and resume capture on the first rising edge after reset deasserts.

Verification
REQ-035 SHALL cover ALU write-back: valid, regWrite, aluResult=0x0000_1234, writeAddress=5 -> next cycle shouldWrite=1, writeAddress=5, writeData=0x0000_1234, retired=1.
REQ-036 SHALL cover load extension: memData=0x8081_F2F3, memToReg=1, aluResult[1:0]=1 -> LB gives 0xFFFF_FFF2; LBU gives 0x0000_00F2; with aluResult[1:0]=2, LH gives 0xFFFF_8081.
REQ-037 SHALL cover misalignment and the $zero rule: LH with aluResult=0x1001 -> misaligned=1, shouldWrite=0; ALU op with writeAddress=0 -> shouldWrite=0, wb_valid=1.
REQ-038 SHALL cover link write-back: link=1, memToReg=1, pc=0x0040_0010 -> writeData=0x0040_0018.
REQ-039 SHALL cover stall/flush interaction: stall=1 for 3 cycles -> outputs and retired frozen; stall=1 and flush=1 together -> wb_valid=0, shouldWrite=0, retired unchanged.
REQ-040 SHALL cover wrap-around and reset: with retired=0xFFFF_FFFF, an accepted instruction -> retired=0; reset asserted between clock edges -> all outputs 0 immediately.
